// File: rtl/vs_indirect_ring_if.sv
// rtl/vs_indirect_ring_if.sv - Wishbone register-window bundle for vs_indirect_ring
//
// Purpose: groups the Wishbone slave handshake/bus signals of vs_indirect_ring.
// Signals:
//   wb_cyc_i, wb_stb_i, wb_we_i  cycle, strobe, write enable (master -> slave)
//   wb_adr_i[15:0]               word address (master -> slave)
//   wb_dat_i[15:0]               write data (master -> slave)
//   wb_dat_o[15:0]               read data, valid while wb_ack_o=1 (slave -> master)
//   wb_ack_o, wb_err_o           single-cycle acknowledge / error (slave -> master)
interface vs_indirect_ring_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/vs_indirect_ring.sv
// rtl/vs_indirect_ring.sv - crash-backup monitor ring buffer behind an indirect Wishbone register
//
// Purpose: captures a 15-bit sample stream into a 2^RB_AW-entry ring. Offset 0 is an
// indirect data register (write 0x0000 freeze+rewind, write 0xFFFF release+clear, read
// pops oldest-first with bit15 flagging the last entry). Offset 1 is status
// {frozen, ovf, cnt[13:0]} (write bit14=1 clears ovf), offset 2 is the remaining count.
// Optional feature macro VS_RB_DROP_CNT_EN: offset 3 becomes a saturating 16-bit count
// of samples dropped while frozen; without it offset 3 errors like any unmapped offset.
// Ports:
//   wb_clk_i           clock
//   wb_rst_i           synchronous active-high reset
//   wb                 Wishbone slave bundle (vs_indirect_ring_if.slave)
//   smp_valid_i        sample strobe
//   smp_data_i[14:0]   sample value
//   frozen_o           buffer frozen (readout mode)
module vs_indirect_ring #(
  parameter logic [15:0] BASE_A = 16'd512,
  parameter int          RB_AW  = 13
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  vs_indirect_ring_if.slave        wb,
  input  logic                     smp_valid_i,
  input  logic [14:0]              smp_data_i,
  output logic                     frozen_o
);

  localparam logic [RB_AW:0] L_DEPTH = {1'b1, {RB_AW{1'b0}}};
  localparam logic [RB_AW:0] L_ONE   = {{RB_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           r_state;
  logic [RB_AW-1:0] r_wp;
  logic [RB_AW-1:0] r_rp;
  logic [RB_AW:0]   r_cnt;
  logic [RB_AW:0]   r_rem;
  logic             r_ovf;
  logic             r_frozen;

  // Transaction pipeline, captured at accept
  logic             r_hit;
  logic             r_pop;
  logic             r_last;
  logic [15:0]      r_rdat;

  logic [14:0]      r_rd_q;
  logic             r_ack;
  logic             r_err;
  logic [15:0]      r_dat;

  logic [14:0]      mem [0:(1<<RB_AW)-1];

  logic             w_accept;
  logic [15:0]      w_off;
  logic             w_hit;
  logic             w_wr0;
  logic             w_freeze;
  logic             w_release;
  logic             w_pop;
  logic             w_capture;
  logic             w_ovf_clr;
  logic [15:0]      w_stat;
  logic [15:0]      w_remr;
  logic [15:0]      w_rdat;

  assign w_accept  = (r_state == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign w_off     = wb.wb_adr_i - BASE_A;
`ifdef VS_RB_DROP_CNT_EN
  assign w_hit     = (w_off <= 16'd3);
`else
  assign w_hit     = (w_off <= 16'd2);
`endif
  assign w_wr0     = w_accept && wb.wb_we_i && (w_off == 16'd0);
  assign w_freeze  = w_wr0 && (wb.wb_dat_i == 16'h0000);
  assign w_release = w_wr0 && (wb.wb_dat_i == 16'hFFFF);
  assign w_pop     = w_accept && !wb.wb_we_i && (w_off == 16'd0) && r_frozen && (r_rem != '0);
  assign w_ovf_clr = w_accept && wb.wb_we_i && (w_off == 16'd1) && wb.wb_dat_i[14];
  // Freeze/release writes take effect at accept, so a coincident sample is dropped too
  assign w_capture = smp_valid_i && !r_frozen && !w_freeze && !w_release;

  assign w_stat = {r_frozen, r_ovf, 14'(r_cnt)};
  assign w_remr = {2'b00, 14'(r_rem)};

`ifdef VS_RB_DROP_CNT_EN
  logic [15:0] r_drop;
  logic        w_drop;

  assign w_drop = smp_valid_i && (r_frozen || w_freeze || w_release);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_drop <= '0;
    end else if (w_release) begin
      r_drop <= {15'd0, smp_valid_i};
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end
`endif

  always_comb begin
    w_rdat = 16'h0000;
    if (!wb.wb_we_i) begin
      case (w_off)
        16'd0:   w_rdat = 16'h8000;
        16'd1:   w_rdat = w_stat;
        16'd2:   w_rdat = w_remr;
`ifdef VS_RB_DROP_CNT_EN
        16'd3:   w_rdat = r_drop;
`endif
        default: w_rdat = 16'h0000;
      endcase
    end
  end

  // Capture writes and readout reads are mutually exclusive through r_frozen
  always_ff @(posedge wb_clk_i) begin
    if (w_capture) begin
      mem[r_wp] <= smp_data_i;
    end
    if (w_pop) begin
      r_rd_q <= mem[r_rp];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_ovf    <= 1'b0;
      r_frozen <= 1'b0;
      r_hit    <= 1'b0;
      r_pop    <= 1'b0;
      r_last   <= 1'b0;
      r_rdat   <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
    end else begin
      if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end

      if (w_capture) begin
        r_wp <= r_wp + 1'b1;
        if (r_cnt == L_DEPTH) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + L_ONE;
        end
      end

      // Oldest entry sits cnt places behind the write pointer
      if (w_freeze) begin
        r_frozen <= 1'b1;
        r_rp     <= r_wp - r_cnt[RB_AW-1:0];
        r_rem    <= r_cnt;
      end

      if (w_release) begin
        r_frozen <= 1'b0;
        r_cnt    <= '0;
        r_rem    <= '0;
        r_ovf    <= 1'b0;
      end

      if (w_pop) begin
        r_rp  <= r_rp + 1'b1;
        r_rem <= r_rem - L_ONE;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_hit   <= w_hit;
            r_pop   <= w_pop;
            r_last  <= (r_rem == L_ONE);
            r_rdat  <= w_rdat;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_ack   <= r_hit;
          r_err   <= !r_hit;
          r_dat   <= !r_hit ? 16'h0000 : (r_pop ? {r_last, r_rd_q} : r_rdat);
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_dat   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign frozen_o    = r_frozen;

endmodule

// File: tb/tb_vs_indirect_ring.sv
// tb/tb_vs_indirect_ring.sv - scoreboard bench for vs_indirect_ring
module tb_vs_indirect_ring;

  logic        clk;
  logic        rst;
  logic        smp_valid;
  logic [14:0] smp_data;
  logic        frozen;

  vs_indirect_ring_if u_if ();

  vs_indirect_ring #(.BASE_A(16'd512), .RB_AW(13)) u_dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (u_if),
    .smp_valid_i (smp_valid),
    .smp_data_i  (smp_data),
    .frozen_o    (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          chk_dat;
    logic [15:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_sample(input logic [14:0] v);
    @(negedge clk);
    smp_valid = 1'b1;
    smp_data  = v;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  // One Wishbone access; optional coincident sample lands in the accept cycle
  task automatic bus(input string tag, input bit we, input logic [15:0] adr,
                     input logic [15:0] dat, input bit exp_err, input logic [15:0] exp_dat,
                     input bit with_smp);
    exp_t e;
    exp_t r;
    int   n;
    e.err     = exp_err;
    e.chk_dat = !we && !exp_err;
    e.dat     = exp_dat;
    exp_q.push_back(e);
    @(negedge clk);
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    u_if.wb_we_i  = we;
    u_if.wb_adr_i = adr;
    u_if.wb_dat_i = dat;
    if (with_smp) begin
      smp_valid = 1'b1;
      smp_data  = 15'h0077;
    end
    n = 0;
    do begin
      @(negedge clk);
      smp_valid = 1'b0;
      n++;
    end while (!u_if.wb_ack_o && !u_if.wb_err_o && n < 10);
    r = exp_q.pop_front();
    check({tag, "_lat"}, n, 2);
    check({tag, "_ack"}, {u_if.wb_err_o, u_if.wb_ack_o}, r.err ? 2'b10 : 2'b01);
    if (r.chk_dat) check({tag, "_dat"}, u_if.wb_dat_o, r.dat);
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    u_if.wb_we_i  = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    smp_valid     = 1'b0;
    smp_data      = '0;
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    u_if.wb_we_i  = 1'b0;
    u_if.wb_adr_i = '0;
    u_if.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", u_if.wb_ack_o, 0);
    check("rst_err", u_if.wb_err_o, 0);
    check("rst_dat", u_if.wb_dat_o, 0);
    check("rst_frz", frozen, 0);

    // Basic readout of 5 samples
    for (int i = 1; i <= 5; i++) push_sample(15'(i));
    bus("frz1", 1, 16'd512, 16'h0000, 0, 16'h0, 0);
    check("frz1_frozen", frozen, 1);
    bus("rd1", 0, 16'd512, 0, 0, 16'h0001, 0);
    bus("rd2", 0, 16'd512, 0, 0, 16'h0002, 0);
    bus("rd3", 0, 16'd512, 0, 0, 16'h0003, 0);
    bus("rd4", 0, 16'd512, 0, 0, 16'h0004, 0);
    bus("rd5", 0, 16'd512, 0, 0, 16'h8005, 0);
    bus("rd6", 0, 16'd512, 0, 0, 16'h8000, 0);
    bus("rel1", 1, 16'd512, 16'hFFFF, 0, 16'h0, 0);
    bus("st_rel1", 0, 16'd513, 0, 0, 16'h0000, 0);

    // Freeze with empty buffer
    bus("frz0", 1, 16'd512, 16'h0000, 0, 16'h0, 0);
    bus("rd_empty", 0, 16'd512, 0, 0, 16'h8000, 0);
    bus("rem_empty", 0, 16'd514, 0, 0, 16'h0000, 0);
    bus("wr_ign", 1, 16'd512, 16'h1234, 0, 16'h0, 0);
    bus("st_frz0", 0, 16'd513, 0, 0, 16'h8000, 0);
    bus("rel2", 1, 16'd512, 16'hFFFF, 0, 16'h0, 0);
    bus("st_rel2", 0, 16'd513, 0, 0, 16'h0000, 0);
    push_sample(15'h0055);
    bus("st_resume", 0, 16'd513, 0, 0, 16'h0001, 0);
    bus("frz2", 1, 16'd512, 16'h0000, 0, 16'h0, 0);
    bus("rem_one", 0, 16'd514, 0, 0, 16'h0001, 0);
    bus("rd_resume", 0, 16'd512, 0, 0, 16'h8055, 0);
    bus("rel3", 1, 16'd512, 16'hFFFF, 0, 16'h0, 0);

    // Unmapped offset
    bus("err4", 0, 16'd516, 0, 1, 16'h0, 0);

    // Reset the cycle after a read accept
    @(negedge clk);
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    u_if.wb_we_i  = 1'b0;
    u_if.wb_adr_i = 16'd513;
    @(negedge clk);
    rst           = 1'b1;
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_resp", {u_if.wb_ack_o, u_if.wb_err_o}, 2'b00);
      rst = 1'b0;
    end
    check("rst_mid_dat", u_if.wb_dat_o, 0);
    check("rst_mid_frz", frozen, 0);

    // Freeze coincident with a sample
    push_sample(15'h0011);
    push_sample(15'h0012);
    bus("frz_coin", 1, 16'd512, 16'h0000, 0, 16'h0, 1);
    bus("rd_coin1", 0, 16'd512, 0, 0, 16'h0011, 0);
    bus("rd_coin2", 0, 16'd512, 0, 0, 16'h8012, 0);
    bus("rd_coin3", 0, 16'd512, 0, 0, 16'h8000, 0);
`ifdef VS_RB_DROP_CNT_EN
    bus("drop1", 0, 16'd515, 0, 0, 16'h0001, 0);
    bus("rel4", 1, 16'd512, 16'hFFFF, 0, 16'h0, 0);
    bus("drop0", 0, 16'd515, 0, 0, 16'h0000, 0);
`else
    bus("drop_err", 0, 16'd515, 0, 1, 16'h0, 0);
    bus("rel4", 1, 16'd512, 16'hFFFF, 0, 16'h0, 0);
`endif

    // Overflow: 8195 samples, values = index
    @(negedge clk);
    for (int i = 0; i < 8195; i++) begin
      smp_valid = 1'b1;
      smp_data  = 15'(i);
      @(negedge clk);
    end
    smp_valid = 1'b0;
    bus("st_ovf", 0, 16'd513, 0, 0, 16'h6000, 0);
    bus("ovf_clr", 1, 16'd513, 16'h4000, 0, 16'h0, 0);
    bus("st_ovf_clr", 0, 16'd513, 0, 0, 16'h2000, 0);
    bus("frz_full", 1, 16'd512, 16'h0000, 0, 16'h0, 0);
    bus("rem_full", 0, 16'd514, 0, 0, 16'h2000, 0);
    for (int i = 0; i < 8192; i++) begin
      logic [15:0] ev;
      ev = {(i == 8191) ? 1'b1 : 1'b0, 15'(i + 3)};
      bus("rd_full", 0, 16'd512, 0, 0, ev, 0);
    end
    bus("rd_full_end", 0, 16'd512, 0, 0, 16'h8000, 0);
    bus("rem_full_end", 0, 16'd514, 0, 0, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vs_indirect_ring.md
Name: vs_indirect_ring

Overview:
- Wishbone slave at the far end of the DMA crash-backup path.
- Captures a continuous 15-bit monitor sample stream into a ring buffer.
- Exposes the buffer through a single indirect data register: writing 0x0000 freezes and rewinds it; successive reads pop oldest-first entries with bit15 marking the last one; writing 0xFFFF releases and clears it.
- A status register and a remaining-count register complete the register window.

Parameters:
- BASE_A, 16'd512: base address of the register window.
- RB_AW, 13: ring buffer address width; depth = 2^RB_AW entries (8192).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_cyc_i  in  1  wishbone cycle
- wb_stb_i  in  1  wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  16  byte-agnostic word address
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data, valid while wb_ack_o=1
- wb_ack_o  out  1  single-cycle acknowledge
- wb_err_o  out  1  single-cycle error
- smp_valid_i  in  1  sample strobe
- smp_data_i  in  15  sample value
- frozen_o  out  1  buffer frozen (readout mode)

Behaviour:
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, frozen_o=0; wp=0, cnt=0, rp=0, rem=0, ovf=0; transaction pipeline cleared.
- Accept: an access is accepted when cyc&stb&we-stable and no access is in flight.
  - Offset = wb_adr_i-BASE_A.
  - Exactly 2 cycles after accept, pulse ack (offset 0..2) or err (any other offset) for 1 cycle.
  - No new accept until the cycle after ack/err.
- Reset mid-access: the access is abandoned; no ack or err is issued.
- Capture (frozen=0), on smp_valid_i:
  - mem[wp]<=smp_data_i; wp<=wp+1 (wraps mod depth).
  - If cnt<depth, cnt++; else the oldest entry is overwritten and ovf<=1.
- Frozen: smp_valid_i samples are dropped.
- Offset 0 write 0x0000 (freeze), at accept:
  - frozen<=1; rp<=wp-cnt (mod depth); rem<=cnt.
  - A sample arriving in the same cycle is dropped.
  - Freeze while already frozen re-rewinds: rp recomputed, rem<=cnt.
- Offset 0 write 0xFFFF (release):
  - frozen<=0; cnt<=0; rem<=0; ovf<=0; wp unchanged.
  - A same-cycle sample is dropped.
- Offset 0 write, any other value: ignored, acked.
- Offset 0 read:
  - If frozen and rem>0: data={rem==1, mem[rp]}; rp++; rem--. Data is sampled from synchronous RAM in the accept+1 cycle.
  - Otherwise (empty, or not frozen): data=0x8000, no pointer change.
- Offset 1 read (status): {frozen, ovf, cnt[13:0]}; cnt reads 0..8192 (14 bits cover depth at RB_AW=13).
- Offset 1 write: bit14=1 clears ovf; other bits ignored.
- Offset 2 read: rem[13:0] zero-extended. Offset 2 write: ignored, acked.
- cnt width RB_AW+1; all pointer arithmetic mod 2^RB_AW.
- Single-port-write/single-port-read RAM; capture writes and readout reads never conflict (exclusive by frozen).

Optional Feature:
- Macro: VS_RB_DROP_CNT_EN.
- Defined:
  - Offset 3 is a read-only 16-bit counter of samples dropped while frozen (including same-cycle freeze/release drops).
  - The counter saturates at 0xFFFF and clears on reset or on a release write.
  - Offset 3 write is acked and ignored.
- Undefined: offset 3 returns wb_err_o like any unmapped offset; no counter logic.

Test Plan:
- Reset, push 5 samples 0x0001..0x0005, write 0x0000 to 512, read 512 x6 -> 0x0001,0x0002,0x0003,0x0004,0x8005,0x8000; ack each exactly 2 cycles after stb.
- Push 8195 samples (values = index) -> status reads 0x6000 (ovf=1, cnt=8192); freeze; first read returns 0x0003 (oldest surviving), 8192nd read returns 0x8000|(8194&0x7FFF).
- Freeze with cnt=0 -> read 512 returns 0x8000, offset 2 reads 0; write 0xFFFF -> status 0x0000, capture resumes.
- Read at offset 4 (address 516) -> wb_err_o pulse 2 cycles after accept, no ack; assert wb_rst_i the cycle after a read accept -> no ack/err, all outputs 0.
- Freeze write coincident with smp_valid_i -> that sample absent from readout; with VS_RB_DROP_CNT_EN, offset 3 reads 1, then 0 after release write.
- Write 0x4000 to offset 1 after overflow -> status bit14 clears, cnt unchanged.
